// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: default widths and the
// launch-FSM state encoding used by uart_tx_buffer.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF = 8;
    localparam int unsigned ADDR_BITS_DEF = 4;

    // Launch FSM state type and its encodings
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Circular byte queue for the TX path. Pointers wrap modulo 2^ADDR_BITS;
// occupancy is kept in a separate ADDR_BITS+1 counter so full and empty are
// unambiguous. All flags come straight from registered state.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   i_wr       in   write strobe (ignored while full)
//   i_data     in   byte to store
//   i_rd       in   pop strobe (ignored while empty)
//   o_rd_data  out  head-of-queue byte
//   o_full     out  queue holds 2^ADDR_BITS entries
//   o_empty    out  queue holds 0 entries
//   o_count    out  current occupancy
//   o_overflow out  sticky, set when a write is rejected
// ---------------------------------------------------------------------------
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_rd,
    output logic [DATA_BITS-1:0] o_rd_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_overflow
);

    localparam int unsigned    DEPTH   = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] CNT_FULL = {1'b1, {ADDR_BITS{1'b0}}};

    logic [DATA_BITS-1:0] r_mem [0:DEPTH-1];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_overflow;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // Full/empty are taken from the pre-edge count, so a write arriving while
    // full is rejected even if a pop frees a slot on the same edge.
    assign w_wr_en = i_wr & ~w_full;
    assign w_rd_en = i_rd & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_wr && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
// Transmit-side byte queue and launch controller in front of the UART TX
// serializer. Host bytes go into uart_fifo; a three-state FSM pops one byte
// at a time, pulses o_tx_start for one cycle, and holds o_tx_data until TX
// reports i_tx_done.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   i_wr        in   host write strobe
//   i_data      in   host byte
//   o_full      out  queue full
//   o_empty     out  queue empty
//   o_count     out  queue occupancy
//   o_overflow  out  sticky write-rejected flag
//   i_tx_done   in   end-of-stop-bit pulse from TX
//   o_tx_start  out  one-cycle launch pulse to TX
//   o_tx_data   out  byte to TX, stable from launch until done
//   o_busy      out  a byte is launched and not yet done
// ---------------------------------------------------------------------------
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_overflow,
    input  logic                 i_tx_done,
    output logic                 o_tx_start,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_busy
);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_tx_data;

    logic [DATA_BITS-1:0] w_head;
    logic                 w_empty;
    logic                 w_pop;

    uart_fifo #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr       (i_wr),
        .i_data     (i_data),
        .i_rd       (w_pop),
        .o_rd_data  (w_head),
        .o_full     (o_full),
        .o_empty    (w_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    // Pop only from IDLE with data present; the popped byte is captured into
    // r_tx_data on the same edge, so a fresh write is never bypassed.
    assign w_pop = (r_state == ST_IDLE) && !w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= w_head;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_empty    = w_empty;
    assign o_tx_start = (r_state == ST_START);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_tx_data  = r_tx_data;

endmodule
